alarm_scheduler: RTL and testbench

Multi-slot alarm controller for the digital clock. It holds four alarm slots, each with a target second-of-day, a ring-length code and an enable. It detects matches against the running time-of-day, queues simultaneous hits and rings them one at a time on a single shared `alarming` output. It sits between the timekeeping counter (which supplies `cur_sec` and `sec_tick`) and the buzzer/LED driver, and replaces per-alarm window comparators with one arbitrated ringer.

---
 rtl/alarm_scheduler.sv | 142 ++++++++++++++
 tb/tb_alarm_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// Four-slot alarm controller: matches slot targets against time-of-day on each
// second tick, queues hits in `pending` and rings them one at a time.
module alarm_scheduler #(
    parameter int unsigned DAY_SECONDS = 86400,
    parameter int unsigned LEN_UNIT    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sec_tick,
    input  logic [16:0] cur_sec,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_slot,
    input  logic [16:0] cfg_sec,
    input  logic [1:0]  cfg_len,
    input  logic        cfg_en,
    input  logic        off,
    output logic        alarming,
    output logic [1:0]  active_slot,
    output logic [3:0]  pending,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        RING = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] tar_q [4];
    logic [16:0] tar_d [4];
    logic [1:0]  len_q [4];
    logic [1:0]  len_d [4];
    logic [3:0]  en_q, en_d;
    logic [3:0]  pending_q, pending_d;
    logic [5:0]  remain_q, remain_d;
    logic [1:0]  active_q, active_d;
    logic [3:0]  hit;
    logic [3:0]  cfg_clr;
    logic [3:0]  avail;
    logic [1:0]  sel;

    function automatic logic [5:0] ring_len(input logic [1:0] code);
        ring_len = 6'((32'(code) + 32'd1) * LEN_UNIT);
    endfunction

    // Slot storage; a write also marks that slot's queued hit as stale.
    always_comb begin
        en_d    = en_q;
        cfg_clr = '0;
        for (int i = 0; i < 4; i++) begin
            tar_d[i] = tar_q[i];
            len_d[i] = len_q[i];
        end
        if (cfg_we) begin
            tar_d[cfg_slot]   = cfg_sec;
            len_d[cfg_slot]   = cfg_len;
            en_d[cfg_slot]    = cfg_en && ({15'd0, cfg_sec} < DAY_SECONDS);
            cfg_clr[cfg_slot] = 1'b1;
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < 4; i++) begin
            hit[i] = sec_tick && en_q[i] && (tar_q[i] == cur_sec) && !cfg_clr[i];
        end
    end

    assign avail = pending_q & ~cfg_clr;

    always_comb begin
        sel = 2'd3;
        casez (avail)
            4'b???1: sel = 2'd0;
            4'b??10: sel = 2'd1;
            4'b?100: sel = 2'd2;
            default: sel = 2'd3;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        active_d  = active_q;
        pending_d = (pending_q | hit) & ~cfg_clr;
        case (state_q)
            IDLE: begin
                if (avail != 4'd0) begin
                    pending_d[sel] = 1'b0;
                    active_d       = sel;
                    remain_d       = ring_len(len_q[sel]);
                    state_d        = RING;
                end
            end
            RING: begin
                // Silence and reconfiguration of the ringing slot beat a tick.
                if (off || (cfg_we && (cfg_slot == active_q))) begin
                    state_d  = IDLE;
                    remain_d = 6'd0;
                end else if (sec_tick) begin
                    if (remain_q <= 6'd1) begin
                        state_d  = IDLE;
                        remain_d = 6'd0;
                    end else begin
                        remain_d = remain_q - 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            remain_q  <= 6'd0;
            active_q  <= 2'd0;
            pending_q <= 4'd0;
            en_q      <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                tar_q[i] <= 17'd0;
                len_q[i] <= 2'd0;
            end
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            en_q      <= en_d;
            for (int i = 0; i < 4; i++) begin
                tar_q[i] <= tar_d[i];
                len_q[i] <= len_d[i];
            end
        end
    end

    assign alarming    = (state_q == RING);
    assign active_slot = active_q;
    assign pending     = pending_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scenario bench for alarm_scheduler: each task drives one scenario, queues the
// expected {state, alarming, active_slot, pending} per cycle and checks them.
module tb_alarm_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sec_tick = 1'b0;
    logic [16:0] cur_sec = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_slot = '0;
    logic [16:0] cfg_sec = '0;
    logic [1:0]  cfg_len = '0;
    logic        cfg_en = 1'b0;
    logic        off = 1'b0;
    logic        alarming;
    logic [1:0]  active_slot;
    logic [3:0]  pending;
    logic        state_dbg;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alarm_scheduler dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .cur_sec(cur_sec),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_sec(cfg_sec),
        .cfg_len(cfg_len), .cfg_en(cfg_en), .off(off),
        .alarming(alarming), .active_slot(active_slot), .pending(pending),
        .state_dbg(state_dbg)
    );

    function automatic logic [7:0] pk(input logic a, input logic [1:0] s, input logic [3:0] p);
        pk = {a, a, s, p};
    endfunction

    task automatic drive(input logic t, input logic [16:0] sec, input logic we,
                         input logic [1:0] slot, input logic [16:0] csec,
                         input logic [1:0] clen, input logic cen, input logic o,
                         input logic r, input logic [7:0] exp);
        sec_tick = t; cur_sec = sec; cfg_we = we; cfg_slot = slot;
        cfg_sec = csec; cfg_len = clen; cfg_en = cen; off = o; rst = r;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got_q.push_back({state_dbg, alarming, active_slot, pending});
        sec_tick = 1'b0; cfg_we = 1'b0; off = 1'b0; rst = 1'b0;
    endtask

    task automatic tick(input int sec, input logic [7:0] exp);
        drive(1'b1, 17'(sec), 1'b0, 2'd0, 17'd0, 2'd0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic idle(input logic [7:0] exp);
        drive(1'b0, 17'd0, 1'b0, 2'd0, 17'd0, 2'd0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic cfg(input logic [1:0] slot, input int csec, input logic [1:0] clen,
                       input logic cen, input logic [7:0] exp);
        drive(1'b0, 17'd0, 1'b1, slot, 17'(csec), clen, cen, 1'b0, 1'b0, exp);
    endtask

    task automatic test_reset();
        int n = 0;
        logic [7:0] e, g;
        drive(1'b1, 17'd0, 1'b1, 2'd1, 17'd0, 2'd0, 1'b1, 1'b0, 1'b1, pk(1'b0, 2'd0, 4'd0));
        drive(1'b0, 17'd0, 1'b0, 2'd0, 17'd0, 2'd0, 1'b0, 1'b0, 1'b1, pk(1'b0, 2'd0, 4'd0));
        idle(pk(1'b0, 2'd0, 4'd0));
        tick(0, pk(1'b0, 2'd0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset[%0d] got=%b exp=%b", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_single();
        int n = 0;
        logic [7:0] e, g;
        cfg(2'd1, 100, 2'd0, 1'b1, pk(1'b0, 2'd0, 4'd0));
        tick(100, pk(1'b0, 2'd0, 4'b0010));
        idle(pk(1'b1, 2'd1, 4'd0));
        for (int j = 1; j <= 15; j++) begin
            tick(100 + j, pk(j < 15, 2'd1, 4'd0));
            idle(pk(j < 15, 2'd1, 4'd0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL single[%0d] got=%b exp=%b", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic [7:0] e, g;
        cfg(2'd0, 500, 2'd1, 1'b1, pk(1'b0, 2'd1, 4'd0));
        cfg(2'd2, 500, 2'd0, 1'b1, pk(1'b0, 2'd1, 4'd0));
        tick(500, pk(1'b0, 2'd1, 4'b0101));
        idle(pk(1'b1, 2'd0, 4'b0100));
        for (int j = 1; j <= 30; j++) begin
            tick(500 + j, pk(j < 30, 2'd0, 4'b0100));
            if (j < 30) idle(pk(1'b1, 2'd0, 4'b0100));
        end
        idle(pk(1'b1, 2'd2, 4'd0));
        for (int j = 1; j <= 15; j++) begin
            tick(530 + j, pk(j < 15, 2'd2, 4'd0));
            idle(pk(j < 15, 2'd2, 4'd0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%b exp=%b", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_off();
        int n = 0;
        logic [7:0] e, g;
        cfg(2'd0, 1000, 2'd1, 1'b1, pk(1'b0, 2'd2, 4'd0));
        cfg(2'd2, 1000, 2'd0, 1'b1, pk(1'b0, 2'd2, 4'd0));
        drive(1'b0, 17'd0, 1'b0, 2'd0, 17'd0, 2'd0, 1'b0, 1'b1, 1'b0, pk(1'b0, 2'd2, 4'd0));
        tick(1000, pk(1'b0, 2'd2, 4'b0101));
        idle(pk(1'b1, 2'd0, 4'b0100));
        for (int j = 1; j <= 3; j++) begin
            tick(1000 + j, pk(1'b1, 2'd0, 4'b0100));
            idle(pk(1'b1, 2'd0, 4'b0100));
        end
        drive(1'b1, 17'd1004, 1'b0, 2'd0, 17'd0, 2'd0, 1'b0, 1'b1, 1'b0, pk(1'b0, 2'd0, 4'b0100));
        idle(pk(1'b1, 2'd2, 4'd0));
        for (int j = 1; j <= 15; j++) begin
            tick(1004 + j, pk(j < 15, 2'd2, 4'd0));
            idle(pk(j < 15, 2'd2, 4'd0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL off[%0d] got=%b exp=%b", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        logic [7:0] e, g;
        cfg(2'd3, 86390, 2'd3, 1'b1, pk(1'b0, 2'd2, 4'd0));
        tick(86390, pk(1'b0, 2'd2, 4'b1000));
        idle(pk(1'b1, 2'd3, 4'd0));
        for (int j = 1; j <= 60; j++) begin
            tick((86390 + j) % 86400, pk(j < 60, 2'd3, 4'd0));
            idle(pk(j < 60, 2'd3, 4'd0));
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL wrap[%0d] got=%b exp=%b", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_invalid_abort();
        int n = 0;
        logic [7:0] e, g;
        cfg(2'd0, 90000, 2'd0, 1'b1, pk(1'b0, 2'd3, 4'd0));
        tick(90000, pk(1'b0, 2'd3, 4'd0));
        idle(pk(1'b0, 2'd3, 4'd0));
        tick(0, pk(1'b0, 2'd3, 4'd0));
        tick(500, pk(1'b0, 2'd3, 4'd0));
        tick(100, pk(1'b0, 2'd3, 4'b0010));
        idle(pk(1'b1, 2'd1, 4'd0));
        tick(101, pk(1'b1, 2'd1, 4'd0));
        cfg(2'd1, 200, 2'd0, 1'b1, pk(1'b0, 2'd1, 4'd0));
        idle(pk(1'b0, 2'd1, 4'd0));
        // write to slot 1 in the same cycle as a tick matching its old target
        drive(1'b1, 17'd200, 1'b1, 2'd1, 17'd300, 2'd0, 1'b1, 1'b0, 1'b0, pk(1'b0, 2'd1, 4'd0));
        idle(pk(1'b0, 2'd1, 4'd0));
        tick(300, pk(1'b0, 2'd1, 4'b0010));
        idle(pk(1'b1, 2'd1, 4'd0));
        tick(300, pk(1'b1, 2'd1, 4'b0010));
        drive(1'b0, 17'd0, 1'b0, 2'd0, 17'd0, 2'd0, 1'b0, 1'b1, 1'b0, pk(1'b0, 2'd1, 4'b0010));
        idle(pk(1'b1, 2'd1, 4'd0));
        drive(1'b0, 17'd0, 1'b0, 2'd0, 17'd0, 2'd0, 1'b0, 1'b1, 1'b0, pk(1'b0, 2'd1, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL invalid_abort[%0d] got=%b exp=%b", n, g, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        logic [7:0] e, g;
        cfg(2'd2, 300, 2'd0, 1'b1, pk(1'b0, 2'd1, 4'd0));
        tick(300, pk(1'b0, 2'd1, 4'b0110));
        idle(pk(1'b1, 2'd1, 4'b0100));
        drive(1'b1, 17'd301, 1'b0, 2'd0, 17'd0, 2'd0, 1'b0, 1'b0, 1'b1, pk(1'b0, 2'd0, 4'd0));
        tick(300, pk(1'b0, 2'd0, 4'd0));
        idle(pk(1'b0, 2'd0, 4'd0));
        tick(100, pk(1'b0, 2'd0, 4'd0));
        tick(86390, pk(1'b0, 2'd0, 4'd0));
        idle(pk(1'b0, 2'd0, 4'd0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL reset_mid[%0d] got=%b exp=%b", n, g, e);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_off();
        test_wrap();
        test_invalid_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
